// File: rtl/proc_pkg.sv
// Shared processor package: default core sizes, the EX/MEM bundle layout
// (reused by MEM/WB) and the elastic-buffer occupancy encoding.
package proc_pkg;

   localparam int PROC_DATA_WIDTH        = 64;
   localparam int PROC_REGFILE_LOG2_DEEP = 5;
   localparam int NUM_THREADS            = 4;
   localparam int TID_W                  = $clog2(NUM_THREADS);

   // Control bits first, then datapath, then ownership tag.
   typedef struct packed {
      logic                              reg_write_en;
      logic                              mem_write_en;
      logic                              mem_to_reg;
      logic [PROC_DATA_WIDTH-1:0]        alu;
      logic [PROC_DATA_WIDTH-1:0]        reg_data2;
      logic [PROC_REGFILE_LOG2_DEEP-1:0] wr_addr;
      logic [TID_W-1:0]                  tid;
   } exmem_bundle_t;

   // Occupancy of the stage buffer: nothing, main only, main plus skid.
   typedef enum logic [1:0] {
      BUF_EMPTY = 2'd0,
      BUF_ONE   = 2'd1,
      BUF_TWO   = 2'd2
   } buf_state_e;

endpackage

// File: rtl/exmem_stage_if.sv
// EX/MEM stage bus: upstream handshake and bundle, flush controls and the
// downstream handshake and registered bundle.
// slave  = the stage itself, master = the surrounding pipeline / bench.
interface exmem_stage_if #(
   parameter int PROC_DATA_WIDTH        = proc_pkg::PROC_DATA_WIDTH,
   parameter int PROC_REGFILE_LOG2_DEEP = proc_pkg::PROC_REGFILE_LOG2_DEEP,
   parameter int NUM_THREADS            = proc_pkg::NUM_THREADS
);
   localparam int TID_W = $clog2(NUM_THREADS);

   // Upstream (EX) side
   logic                              valid_i;
   logic                              ready_o;
   logic                              reg_write_en_i;
   logic                              mem_write_en_i;
   logic                              mem_to_reg_i;
   logic [PROC_DATA_WIDTH-1:0]        alu_i;
   logic [PROC_DATA_WIDTH-1:0]        reg_data2_i;
   logic [PROC_REGFILE_LOG2_DEEP-1:0] reg_write_addr_i;
   logic [TID_W-1:0]                  thread_id_i;

   // Per-thread flush
   logic                              flush_i;
   logic [NUM_THREADS-1:0]            flush_mask_i;

   // Downstream (MEM) side
   logic                              valid_o;
   logic                              ready_i;
   logic                              reg_write_en_o;
   logic                              mem_write_en_o;
   logic                              mem_to_reg_o;
   logic [PROC_DATA_WIDTH-1:0]        alu_o;
   logic [PROC_DATA_WIDTH-1:0]        reg_data2_o;
   logic [PROC_REGFILE_LOG2_DEEP-1:0] reg_write_addr_o;
   logic [TID_W-1:0]                  thread_id_o;

   modport slave (
      input  valid_i, reg_write_en_i, mem_write_en_i, mem_to_reg_i,
      input  alu_i, reg_data2_i, reg_write_addr_i, thread_id_i,
      input  flush_i, flush_mask_i, ready_i,
      output ready_o, valid_o, reg_write_en_o, mem_write_en_o, mem_to_reg_o,
      output alu_o, reg_data2_o, reg_write_addr_o, thread_id_o
   );

   modport master (
      output valid_i, reg_write_en_i, mem_write_en_i, mem_to_reg_i,
      output alu_i, reg_data2_i, reg_write_addr_i, thread_id_i,
      output flush_i, flush_mask_i, ready_i,
      input  ready_o, valid_o, reg_write_en_o, mem_write_en_o, mem_to_reg_o,
      input  alu_o, reg_data2_o, reg_write_addr_o, thread_id_o
   );

endinterface

// File: rtl/pipe_skid_buf.sv
// Generic-payload elastic buffer with per-entry kill inputs.
// Build option EXMEM_SKID_EN: when defined, a two-entry skid buffer whose
// ready is a flop (no ready path from i_ready to o_ready); when undefined, a
// single register with combinational ready = ~valid | i_ready.
// Kills are applied after the accept/consume movement: a killed input is
// dropped although the upstream sees it accepted, killed held entries vanish
// at the same edge and a surviving skid entry moves into main.
module pipe_skid_buf #(
   parameter int W = 8
) (
   input  logic         i_clk,
   input  logic         i_rst_n,
   // upstream
   input  logic         i_valid,
   output logic         o_ready,
   input  logic [W-1:0] i_data,
   input  logic         i_kill_in,
   // downstream
   output logic         o_valid,
   input  logic         i_ready,
   output logic [W-1:0] o_data,
   // held entries, exposed so the owner can decide which to kill
   output logic [W-1:0] o_skid_data,
   input  logic         i_kill_main,
   input  logic         i_kill_skid
);
   import proc_pkg::*;

   buf_state_e   r_state_reg;
   buf_state_e   r_state_next;
   logic [W-1:0] r_main_reg;
   logic [W-1:0] r_main_next;
   logic [W-1:0] r_skid_reg;
   logic [W-1:0] r_skid_next;

   logic         w_main_valid;
   logic         w_skid_valid;
   logic         w_in_ready;
   logic         w_accept;
   logic         w_consume;
   logic         w_keep_main;
   logic         w_keep_skid;
   logic         w_keep_in;

   assign w_main_valid = (r_state_reg != BUF_EMPTY);

`ifdef EXMEM_SKID_EN
   logic r_ready_reg;

   assign w_skid_valid = (r_state_reg == BUF_TWO);

   // Registered ready: open whenever the next occupancy leaves a free slot.
   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         r_ready_reg <= 1'b1;
      end else begin
         r_ready_reg <= (r_state_next != BUF_TWO);
      end
   end

   // Gated by reset so the upstream never sees ready while reset is held.
   assign w_in_ready = r_ready_reg & i_rst_n;
`else
   assign w_skid_valid = 1'b0;
   assign w_in_ready   = (~w_main_valid | i_ready) & i_rst_n;
`endif

   assign w_accept    = i_valid & w_in_ready;
   assign w_consume   = w_main_valid & i_ready;

   // Survivors of this edge, oldest first: main, skid, then the new input.
   assign w_keep_main = w_main_valid & ~w_consume & ~i_kill_main;
   assign w_keep_skid = w_skid_valid & ~i_kill_skid;
   assign w_keep_in   = w_accept & ~i_kill_in;

   // Next occupancy and entry placement: pack survivors into main then skid.
   always_comb begin
      r_state_next = BUF_EMPTY;
      r_main_next  = r_main_reg;
      r_skid_next  = r_skid_reg;
      if (w_keep_main) begin
         r_state_next = BUF_ONE;
         if (w_keep_skid) begin
            r_state_next = BUF_TWO;
         end else if (w_keep_in) begin
            r_state_next = BUF_TWO;
            r_skid_next  = i_data;
         end
      end else if (w_keep_skid) begin
         r_state_next = BUF_ONE;
         r_main_next  = r_skid_reg;
         if (w_keep_in) begin
            r_state_next = BUF_TWO;
            r_skid_next  = i_data;
         end
      end else if (w_keep_in) begin
         r_state_next = BUF_ONE;
         r_main_next  = i_data;
      end
   end

   // Occupancy register.
   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         r_state_reg <= BUF_EMPTY;
      end else begin
         r_state_reg <= r_state_next;
      end
   end

   // Payload registers; cleared on reset, otherwise hold when not reloaded.
   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         r_main_reg <= '0;
         r_skid_reg <= '0;
      end else begin
         r_main_reg <= r_main_next;
         r_skid_reg <= r_skid_next;
      end
   end

   assign o_ready     = w_in_ready;
   assign o_valid     = w_main_valid;
   assign o_data      = r_main_reg;
   assign o_skid_data = r_skid_reg;

endmodule

// File: rtl/exmem_stage.sv
// EX/MEM pipeline stage of the multithreaded core: registers the EX result and
// control bundle with one cycle of latency behind a valid/ready handshake and
// supports per-thread flush of the in-flight op(s).
// Build option EXMEM_SKID_EN selects the two-entry skid buffer inside
// pipe_skid_buf; without it the stage is a single register.
module exmem_stage #(
   parameter int PROC_DATA_WIDTH        = proc_pkg::PROC_DATA_WIDTH,
   parameter int PROC_REGFILE_LOG2_DEEP = proc_pkg::PROC_REGFILE_LOG2_DEEP,
   parameter int NUM_THREADS            = proc_pkg::NUM_THREADS
) (
   input  logic          clk_i,
   input  logic          rst_ni,
   exmem_stage_if.slave  bus
);
   localparam int TID_W = $clog2(NUM_THREADS);

   import proc_pkg::*;

   // Same layout as proc_pkg::exmem_bundle_t, sized by this instance's
   // parameters so non-default cores still get a matching bundle.
   typedef struct packed {
      logic                              reg_write_en;
      logic                              mem_write_en;
      logic                              mem_to_reg;
      logic [PROC_DATA_WIDTH-1:0]        alu;
      logic [PROC_DATA_WIDTH-1:0]        reg_data2;
      logic [PROC_REGFILE_LOG2_DEEP-1:0] wr_addr;
      logic [TID_W-1:0]                  tid;
   } stage_bundle_t;

   localparam int BUNDLE_W = $bits(stage_bundle_t);

   stage_bundle_t w_in_bundle;
   stage_bundle_t w_main_bundle;
   stage_bundle_t w_skid_bundle;
   logic          w_kill_in;
   logic          w_kill_main;
   logic          w_kill_skid;
   logic          w_valid;
   logic          w_ready;

   // Pack the upstream signals into one payload word.
   always_comb begin
      w_in_bundle              = '0;
      w_in_bundle.reg_write_en = bus.reg_write_en_i;
      w_in_bundle.mem_write_en = bus.mem_write_en_i;
      w_in_bundle.mem_to_reg   = bus.mem_to_reg_i;
      w_in_bundle.alu          = bus.alu_i;
      w_in_bundle.reg_data2    = bus.reg_data2_i;
      w_in_bundle.wr_addr      = bus.reg_write_addr_i;
      w_in_bundle.tid          = bus.thread_id_i;
   end

   // An entry dies when a flush is requested for its owning thread. Held
   // entries are tested on their registered tid, so no path from ready_i.
   assign w_kill_in   = bus.flush_i & bus.flush_mask_i[w_in_bundle.tid];
   assign w_kill_main = bus.flush_i & bus.flush_mask_i[w_main_bundle.tid];
   assign w_kill_skid = bus.flush_i & bus.flush_mask_i[w_skid_bundle.tid];

   pipe_skid_buf #(
      .W (BUNDLE_W)
   ) u_buf (
      .i_clk       (clk_i),
      .i_rst_n     (rst_ni),
      .i_valid     (bus.valid_i),
      .o_ready     (w_ready),
      .i_data      (w_in_bundle),
      .i_kill_in   (w_kill_in),
      .o_valid     (w_valid),
      .i_ready     (bus.ready_i),
      .o_data      (w_main_bundle),
      .o_skid_data (w_skid_bundle),
      .i_kill_main (w_kill_main),
      .i_kill_skid (w_kill_skid)
   );

   assign bus.ready_o          = w_ready;
   assign bus.valid_o          = w_valid;

   // Control bits must never fire from an empty stage; data simply holds.
   assign bus.reg_write_en_o   = w_main_bundle.reg_write_en & w_valid;
   assign bus.mem_write_en_o   = w_main_bundle.mem_write_en & w_valid;
   assign bus.mem_to_reg_o     = w_main_bundle.mem_to_reg & w_valid;
   assign bus.alu_o            = w_main_bundle.alu;
   assign bus.reg_data2_o      = w_main_bundle.reg_data2;
   assign bus.reg_write_addr_o = w_main_bundle.wr_addr;
   assign bus.thread_id_o      = w_main_bundle.tid;

endmodule

// File: tb/tb_exmem_stage.sv
// Self-checking bench for exmem_stage: a queue scoreboard follows every
// accepted op and per-thread flush, scenario tasks check the plan items inline.
module tb_exmem_stage;
   import proc_pkg::*;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;

   exmem_stage_if bus ();

   exmem_stage dut (
      .clk_i  (clk),
      .rst_ni (rst_n),
      .bus    (bus)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        rwe;
      logic        mwe;
      logic        m2r;
      logic [63:0] alu;
      logic [63:0] d2;
      logic [4:0]  wa;
      logic [1:0]  tid;
   } exp_t;

   exp_t q[$];
   int   n_pass  = 0;
   int   n_total = 0;

`ifdef EXMEM_SKID_EN
   localparam int EXP_ABSORB = 2;
`else
   localparam int EXP_ABSORB = 1;
`endif

   // Scoreboard: compare outputs against the oldest expected op, then pop on
   // consume, drop flushed entries, push newly accepted ops.
   always @(negedge clk) begin : monitor
      exp_t e;
      if (!rst_n) begin
         q.delete();
      end else begin
         n_total++;
         if (bus.valid_o !== (q.size() != 0)) begin
            $display("FAIL sb_valid: valid_o=%b expected=%b", bus.valid_o, (q.size() != 0));
         end else n_pass++;
         if (q.size() != 0) begin
            e = q[0];
            n_total++;
            if ({bus.reg_write_en_o, bus.mem_write_en_o, bus.mem_to_reg_o, bus.alu_o,
                 bus.reg_data2_o, bus.reg_write_addr_o, bus.thread_id_o} !==
                {e.rwe, e.mwe, e.m2r, e.alu, e.d2, e.wa, e.tid}) begin
               $display("FAIL sb_bundle: got tid=%0d alu=%h ctl=%b%b%b expected tid=%0d alu=%h ctl=%b%b%b",
                        bus.thread_id_o, bus.alu_o, bus.reg_write_en_o, bus.mem_write_en_o,
                        bus.mem_to_reg_o, e.tid, e.alu, e.rwe, e.mwe, e.m2r);
            end else n_pass++;
         end else begin
            n_total++;
            if ({bus.reg_write_en_o, bus.mem_write_en_o, bus.mem_to_reg_o} !== 3'b000) begin
               $display("FAIL sb_ctl_idle: ctl=%b%b%b expected 000",
                        bus.reg_write_en_o, bus.mem_write_en_o, bus.mem_to_reg_o);
            end else n_pass++;
         end
         if (bus.valid_o && bus.ready_i && q.size() != 0) begin
            e = q.pop_front();
            $display("out tid=%0d alu=%h", e.tid, e.alu);
         end
         if (bus.flush_i) begin
            for (int i = q.size() - 1; i >= 0; i--) begin
               if (bus.flush_mask_i[q[i].tid]) q.delete(i);
            end
         end
         if (bus.valid_i && bus.ready_o) begin
            if (bus.flush_i && bus.flush_mask_i[bus.thread_id_i]) begin
               $display("in  tid=%0d alu=%h dropped by flush", bus.thread_id_i, bus.alu_i);
            end else begin
               e.rwe = bus.reg_write_en_i;  e.mwe = bus.mem_write_en_i;
               e.m2r = bus.mem_to_reg_i;    e.alu = bus.alu_i;
               e.d2  = bus.reg_data2_i;     e.wa  = bus.reg_write_addr_i;
               e.tid = bus.thread_id_i;
               q.push_back(e);
               $display("in  tid=%0d alu=%h", e.tid, e.alu);
            end
         end
      end
   end

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: simulation did not finish, time=%0t expected < 200000", $time);
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      bus.valid_i      = 1'b0;
      bus.flush_i      = 1'b0;
      bus.flush_mask_i = '0;
   endtask

   task automatic drive(input logic [63:0] alu, input logic [1:0] tid, input logic [2:0] ctl);
      logic [4:0] lo;
      lo                   = alu[4:0];
      bus.valid_i          = 1'b1;
      bus.alu_i            = alu;
      bus.reg_data2_i      = ~alu;
      bus.reg_write_addr_i = lo ^ {3'b000, tid};
      bus.thread_id_i      = tid;
      {bus.reg_write_en_i, bus.mem_write_en_i, bus.mem_to_reg_i} = ctl;
   endtask

   task automatic drain();
      idle();
      bus.ready_i = 1'b1;
      for (int c = 0; c < 20 && q.size() != 0; c++) tick();
      tick();
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      idle();
      bus.ready_i = 1'b0;
      tick();
      tick();
      n_total++;
      if ({bus.valid_o, bus.reg_write_en_o, bus.mem_write_en_o, bus.mem_to_reg_o, bus.alu_o,
           bus.reg_data2_o, bus.reg_write_addr_o, bus.thread_id_o} !== '0) begin
         $display("FAIL reset_outputs: valid=%b alu=%h tid=%0d expected all 0",
                  bus.valid_o, bus.alu_o, bus.thread_id_o);
      end else n_pass++;
      n_total++;
      if (bus.ready_o !== 1'b0) $display("FAIL reset_ready_low: ready_o=%b expected 0", bus.ready_o);
      else n_pass++;
      rst_n = 1'b1;
      #1;
      n_total++;
      if (bus.ready_o !== 1'b1) $display("FAIL reset_ready_release: ready_o=%b expected 1", bus.ready_o);
      else n_pass++;
   endtask

   task automatic test_single();
      bus.ready_i = 1'b1;
      drive(64'h1234, 2'd2, 3'b110);
      tick();
      idle();
      n_total++;
      if ({bus.valid_o, bus.alu_o, bus.thread_id_o, bus.reg_write_en_o} !== {1'b1, 64'h1234, 2'd2, 1'b1}) begin
         $display("FAIL single_out: valid=%b alu=%h tid=%0d rwe=%b expected 1 1234 2 1",
                  bus.valid_o, bus.alu_o, bus.thread_id_o, bus.reg_write_en_o);
      end else n_pass++;
      tick();
      n_total++;
      if ({bus.valid_o, bus.reg_write_en_o, bus.mem_write_en_o, bus.mem_to_reg_o} !== 4'b0000) begin
         $display("FAIL single_empty: valid=%b ctl=%b%b%b expected 0 000", bus.valid_o,
                  bus.reg_write_en_o, bus.mem_write_en_o, bus.mem_to_reg_o);
      end else n_pass++;
      n_total++;
      if (bus.alu_o !== 64'h1234) $display("FAIL single_hold_data: alu_o=%h expected 1234", bus.alu_o);
      else n_pass++;
   endtask

   task automatic test_back_to_back();
      bus.ready_i = 1'b1;
      for (int i = 0; i < 8; i++) begin
         drive(64'h100 + 64'(i), 2'(i), 3'(i));
         tick();
         n_total++;
         if ({bus.valid_o, bus.alu_o} !== {1'b1, 64'h100 + 64'(i)}) begin
            $display("FAIL b2b_op%0d: valid=%b alu=%h expected 1 %h", i, bus.valid_o, bus.alu_o,
                     64'h100 + 64'(i));
         end else n_pass++;
      end
      idle();
      tick();
      n_total++;
      if (bus.valid_o !== 1'b0) $display("FAIL b2b_end: valid_o=%b expected 0", bus.valid_o);
      else n_pass++;
   endtask

   task automatic test_skid();
      int k   = 0;
      int acc = 0;
      bus.ready_i = 1'b0;
      for (int c = 0; c < 3; c++) begin
         drive(64'h201 + 64'(k), 2'(k + 1), 3'b101);
         @(negedge clk);
         if (c == 2) begin
            n_total++;
            if (bus.ready_o !== 1'b0) $display("FAIL skid_ready_third: ready_o=%b expected 0", bus.ready_o);
            else n_pass++;
         end
         if (bus.ready_o === 1'b1) begin
            k++;
            acc++;
         end
         tick();
      end
      n_total++;
      if (acc !== EXP_ABSORB) $display("FAIL skid_absorbed: accepted=%0d expected %0d", acc, EXP_ABSORB);
      else n_pass++;
      bus.ready_i = 1'b1;
      for (int c = 0; c < 10 && k < 3; c++) begin
         drive(64'h201 + 64'(k), 2'(k + 1), 3'b101);
         @(negedge clk);
         if (bus.ready_o === 1'b1) k++;
         tick();
      end
      drain();
      n_total++;
      if ({k, q.size()} !== {32'd3, 32'd0}) begin
         $display("FAIL skid_drain: accepted=%0d pending=%0d expected 3 0", k, q.size());
      end else n_pass++;
   endtask

   task automatic test_flush_two();
      idle();
      bus.ready_i = 1'b0;
      drive(64'h301, 2'd1, 3'b100);
      tick();
`ifdef EXMEM_SKID_EN
      drive(64'h303, 2'd3, 3'b010);
      tick();
      idle();
      n_total++;
      if (bus.ready_o !== 1'b0) $display("FAIL flush_two_full: ready_o=%b expected 0", bus.ready_o);
      else n_pass++;
      bus.flush_i      = 1'b1;
      bus.flush_mask_i = 4'b0010;
      tick();
      idle();
      n_total++;
      if ({bus.valid_o, bus.thread_id_o, bus.alu_o, bus.ready_o} !== {1'b1, 2'd3, 64'h303, 1'b1}) begin
         $display("FAIL flush_two_promote: valid=%b tid=%0d alu=%h ready=%b expected 1 3 303 1",
                  bus.valid_o, bus.thread_id_o, bus.alu_o, bus.ready_o);
      end else n_pass++;
      bus.flush_i      = 1'b1;
      bus.flush_mask_i = 4'b0101;
      tick();
      idle();
      n_total++;
      if ({bus.valid_o, bus.thread_id_o} !== {1'b1, 2'd3}) begin
         $display("FAIL flush_unmasked: valid=%b tid=%0d expected 1 3", bus.valid_o, bus.thread_id_o);
      end else n_pass++;
`else
      idle();
      bus.flush_i      = 1'b1;
      bus.flush_mask_i = 4'b0010;
      tick();
      idle();
      n_total++;
      if ({bus.valid_o, bus.ready_o} !== {1'b0, 1'b1}) begin
         $display("FAIL flush_main: valid=%b ready=%b expected 0 1", bus.valid_o, bus.ready_o);
      end else n_pass++;
`endif
      drain();
      n_total++;
      if (q.size() !== 0) $display("FAIL flush_two_drain: pending=%0d expected 0", q.size());
      else n_pass++;
   endtask

   task automatic test_flush_accept();
      bus.ready_i      = 1'b1;
      drive(64'h400, 2'd0, 3'b010);
      bus.flush_i      = 1'b1;
      bus.flush_mask_i = 4'b0001;
      @(negedge clk);
      n_total++;
      if (bus.ready_o !== 1'b1) $display("FAIL flush_in_ready: ready_o=%b expected 1", bus.ready_o);
      else n_pass++;
      tick();
      idle();
      n_total++;
      if ({bus.valid_o, bus.mem_write_en_o} !== 2'b00) begin
         $display("FAIL flush_in_drop: valid=%b mwe=%b expected 0 0", bus.valid_o, bus.mem_write_en_o);
      end else n_pass++;
      drive(64'h401, 2'd1, 3'b010);
      bus.flush_i      = 1'b1;
      bus.flush_mask_i = 4'b0001;
      tick();
      idle();
      n_total++;
      if ({bus.valid_o, bus.thread_id_o, bus.mem_write_en_o} !== {1'b1, 2'd1, 1'b1}) begin
         $display("FAIL flush_in_other: valid=%b tid=%0d mwe=%b expected 1 1 1",
                  bus.valid_o, bus.thread_id_o, bus.mem_write_en_o);
      end else n_pass++;
      drain();
   endtask

   task automatic test_reset_mid();
      bus.ready_i = 1'b0;
      drive(64'h501, 2'd1, 3'b111);
      tick();
      drive(64'h502, 2'd2, 3'b111);
      tick();
      idle();
      rst_n = 1'b0;
      tick();
      n_total++;
      if ({bus.valid_o, bus.reg_write_en_o, bus.mem_write_en_o, bus.mem_to_reg_o, bus.alu_o,
           bus.reg_data2_o, bus.reg_write_addr_o, bus.thread_id_o} !== '0) begin
         $display("FAIL midreset_outputs: valid=%b alu=%h tid=%0d expected all 0",
                  bus.valid_o, bus.alu_o, bus.thread_id_o);
      end else n_pass++;
      n_total++;
      if (bus.ready_o !== 1'b0) $display("FAIL midreset_ready: ready_o=%b expected 0", bus.ready_o);
      else n_pass++;
      rst_n       = 1'b1;
      bus.ready_i = 1'b1;
      #1;
      n_total++;
      if (bus.ready_o !== 1'b1) $display("FAIL midreset_release: ready_o=%b expected 1", bus.ready_o);
      else n_pass++;
      for (int c = 0; c < 3; c++) begin
         tick();
         n_total++;
         if (bus.valid_o !== 1'b0) $display("FAIL midreset_stale%0d: valid_o=%b expected 0", c, bus.valid_o);
         else n_pass++;
      end
   endtask

   initial begin
      bus.valid_i          = 1'b0;
      bus.reg_write_en_i   = 1'b0;
      bus.mem_write_en_i   = 1'b0;
      bus.mem_to_reg_i     = 1'b0;
      bus.alu_i            = '0;
      bus.reg_data2_i      = '0;
      bus.reg_write_addr_i = '0;
      bus.thread_id_i      = '0;
      bus.flush_i          = 1'b0;
      bus.flush_mask_i     = '0;
      bus.ready_i          = 1'b0;
      test_reset();
      test_single();
      test_back_to_back();
      test_skid();
      test_flush_two();
      test_flush_accept();
      test_reset_mid();
      tick();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
